// File: rtl/uart_tx_pkg.sv
// Shared types, default timing constants and small helpers for the um245r transmit path.
package uart_tx_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} tx_state_t;

   localparam int DEF_DEPTH          = 8;
   localparam int DEF_SETUP_CYCLES   = 1;
   localparam int DEF_WR_HIGH_CYCLES = 2;
   localparam int DEF_HOLD_CYCLES    = 1;
   localparam int DEF_LOG            = 0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   function automatic string stateName(input tx_state_t s);
      case (s)
         IDLE:    return "IDLE";
         SETUP:   return "SETUP";
         STROBE:  return "STROBE";
         HOLD:    return "HOLD";
         default: return "???";
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; full flag is registered alongside the count.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     system_clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             push_ok, pop_ok;

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && (!full_q || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
      full_d = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge system_clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge system_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Buffers CPU bytes and strobes them into the um245r FIFO honouring _txe.
// Optional saturating drop counter enabled by defining UART_TX_DROP_CNT_EN.
//
// state  | meaning
// IDLE   | wait for data and _txe low; pop head into uart_d, enable driver
// SETUP  | data driven, WR low, SETUP_CYCLES long
// STROBE | WR high for WR_HIGH_CYCLES; um245r latches on the falling edge
// HOLD   | data held HOLD_CYCLES after WR falls, then driver released
module uart_tx_sequencer
   import uart_tx_pkg::*;
#(
   parameter int DEPTH          = DEF_DEPTH,
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int WR_HIGH_CYCLES = DEF_WR_HIGH_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int LOG            = DEF_LOG
) (
   input  logic                     system_clk,
   input  logic                     reset,
   input  logic                     wr_req,
   input  logic [7:0]               wr_data,
   input  logic                     _txe,
   output logic [7:0]               uart_d,
   output logic                     uart_d_oe,
   output logic                     uart_wr,
   output logic                     _flag_do,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               drop_count
);

   localparam int PW = $clog2(max3(SETUP_CYCLES, WR_HIGH_CYCLES, HOLD_CYCLES)) + 1;
   localparam logic [PW-1:0] SETUP_LD  = PW'(SETUP_CYCLES - 1);
   localparam logic [PW-1:0] STROBE_LD = PW'(WR_HIGH_CYCLES - 1);
   localparam logic [PW-1:0] HOLD_LD   = PW'(HOLD_CYCLES - 1);

   tx_state_t     state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          uart_wr_q, uart_wr_d;
   logic          uart_d_oe_q, uart_d_oe_d;
   logic [7:0]    uart_d_q, uart_d_d;

   logic          pop;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .system_clk (system_clk),
      .reset      (reset),
      .push       (wr_req),
      .pop        (pop),
      .wr_data    (wr_data),
      .rd_data    (fifo_rdata),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // Phase timer loads N-1 on entry and advances when it reaches zero.
   always_comb begin
      pop         = (state_q == IDLE) && !fifo_empty && !_txe;
      state_d     = state_q;
      phase_d     = phase_q;
      uart_wr_d   = uart_wr_q;
      uart_d_oe_d = uart_d_oe_q;
      uart_d_d    = uart_d_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d     = SETUP;
               phase_d     = SETUP_LD;
               uart_d_d    = fifo_rdata;
               uart_d_oe_d = 1'b1;
            end
         end
         SETUP: begin
            if (phase_q == '0) begin
               state_d   = STROBE;
               phase_d   = STROBE_LD;
               uart_wr_d = 1'b1;
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         STROBE: begin
            if (phase_q == '0) begin
               state_d   = HOLD;
               phase_d   = HOLD_LD;
               uart_wr_d = 1'b0;
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         HOLD: begin
            if (phase_q == '0) begin
               state_d     = IDLE;
               uart_d_oe_d = 1'b0;
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge system_clk) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         uart_wr_q   <= 1'b0;
         uart_d_oe_q <= 1'b0;
         uart_d_q    <= 8'h00;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         uart_wr_q   <= uart_wr_d;
         uart_d_oe_q <= uart_d_oe_d;
         uart_d_q    <= uart_d_d;
      end
   end

   assign uart_wr   = uart_wr_q;
   assign uart_d_oe = uart_d_oe_q;
   assign uart_d    = uart_d_q;
   assign _flag_do  = fifo_full;

`ifdef UART_TX_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (wr_req && fifo_full && !pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge system_clk) begin
      if (reset) drop_q <= 8'h00;
      else       drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`else
   assign drop_count = 8'h00;
`endif

   always @(posedge system_clk) begin
      if (!reset && wr_req) assert (!$isunknown(wr_data)) else $error("wr_data unknown with wr_req");
      if (!reset) assert (!$isunknown(uart_wr_q)) else $error("uart_wr unknown after reset");
   end

   if (LOG != 0) begin : g_log
      always @(posedge system_clk) begin
         if (!reset) begin
            if (wr_req && (!fifo_full || pop)) $info("push %02h", wr_data);
            if (pop) $info("pop %02h", fifo_rdata);
            if (state_d != state_q) $info("state %s -> %s", stateName(state_q), stateName(state_d));
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a byte scoreboard checked on every WR rise.
module tb_uart_tx_sequencer;

   logic       system_clk = 1'b0;
   logic       reset;
   logic       wr_req;
   logic [7:0] wr_data;
   logic       txe_n;
   logic [7:0] uart_d;
   logic       uart_d_oe;
   logic       uart_wr;
   logic       flag_do;
   logic [3:0] fifo_count;
   logic [7:0] drop_count;

`ifdef UART_TX_DROP_CNT_EN
   localparam logic [7:0] DROP_ONE = 8'h01;
   localparam logic [7:0] DROP_SAT = 8'hFF;
`else
   localparam logic [7:0] DROP_ONE = 8'h00;
   localparam logic [7:0] DROP_SAT = 8'h00;
`endif

   int         checks  = 0;
   int         errors  = 0;
   int         cyc     = 0;
   int         n_rises = 0;
   logic [7:0] sb [$];
   int         rise_cyc [$];
   logic       prev_wr = 1'b0;

   uart_tx_sequencer dut (
      .system_clk (system_clk),
      .reset      (reset),
      .wr_req     (wr_req),
      .wr_data    (wr_data),
      ._txe       (txe_n),
      .uart_d     (uart_d),
      .uart_d_oe  (uart_d_oe),
      .uart_wr    (uart_wr),
      ._flag_do   (flag_do),
      .fifo_count (fifo_count),
      .drop_count (drop_count)
   );

   always #5 system_clk = ~system_clk;
   always @(posedge system_clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b, input bit accepted);
      wr_req  = 1'b1;
      wr_data = b;
      @(posedge system_clk);
      #1;
      wr_req  = 1'b0;
      if (accepted) sb.push_back(b);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int  n;
      bit  done;
      n = 0;
      @(negedge system_clk);
      done = (sb.size() == 0) && (uart_d_oe === 1'b0) && (fifo_count === 4'd0);
      while (!done && n < budget) begin
         @(negedge system_clk);
         n++;
         done = (sb.size() == 0) && (uart_d_oe === 1'b0) && (fifo_count === 4'd0);
      end
      chk(tag, done, 1);
   endtask

   // Each WR rising edge must carry the oldest outstanding byte.
   always @(negedge system_clk) begin
      logic [7:0] exp_b;
      if (reset === 1'b1) begin
         prev_wr = 1'b0;
      end else begin
         if (uart_wr === 1'b1 && prev_wr === 1'b0) begin
            n_rises++;
            rise_cyc.push_back(cyc);
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_b = sb.pop_front();
               chk("uart_d_at_wr", uart_d, exp_b);
            end
            chk("d_oe_at_wr", uart_d_oe, 1);
         end
         prev_wr = uart_wr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int n;
      reset   = 1'b1;
      wr_req  = 1'b0;
      wr_data = 8'h00;
      txe_n   = 1'b0;

      // Reset values
      repeat (3) @(posedge system_clk);
      @(negedge system_clk);
      chk("rst_wr", uart_wr, 0);
      chk("rst_oe", uart_d_oe, 0);
      chk("rst_d", uart_d, 0);
      chk("rst_flag", flag_do, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_drop", drop_count, 0);
      @(posedge system_clk);
      #1;
      reset = 1'b0;

      // Single byte cycle-exact timing
      push(8'h41, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge system_clk);
         chk($sformatf("t1_wr_c%0d", k), uart_wr, (k == 3 || k == 4));
         chk($sformatf("t1_oe_c%0d", k), uart_d_oe, (k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) chk($sformatf("t1_d_c%0d", k), uart_d, 8'h41);
         if (k == 1) chk("t1_count_c1", fifo_count, 1);
         if (k == 7) chk("t1_count_c7", fifo_count, 0);
      end

      // Fill while device busy
      @(posedge system_clk);
      #1;
      txe_n = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(i), 1'b1);
      @(negedge system_clk);
      chk("t2_count_full", fifo_count, 8);
      chk("t2_flag_full", flag_do, 1);
      r0 = n_rises;
      repeat (10) @(negedge system_clk);
      chk("t2_no_wr", n_rises, r0);
      chk("t2_count_hold", fifo_count, 8);

      // Rejected pushes and drop counter saturation
      push(8'hAA, 1'b0);
      @(negedge system_clk);
      chk("t3_count", fifo_count, 8);
      chk("t3_drop_one", drop_count, DROP_ONE);
      for (int i = 0; i < 299; i++) push(8'hAA, 1'b0);
      @(negedge system_clk);
      chk("t3_drop_sat", drop_count, DROP_SAT);
      chk("t3_count_after", fifo_count, 8);

      // Push on the pop cycle of a full FIFO, then drain with spacing check
      @(posedge system_clk);
      #1;
      rise_cyc.delete();
      txe_n = 1'b0;
      push(8'h08, 1'b1);
      @(negedge system_clk);
      chk("t4_count_stays", fifo_count, 8);
      chk("t4_flag_stays", flag_do, 1);
      wait_drain(120, "t4_drain");
      chk("t4_nbytes", rise_cyc.size(), 9);
      for (int i = 1; i < rise_cyc.size(); i++)
         chk($sformatf("t4_spacing_%0d", i), rise_cyc[i] - rise_cyc[i-1], 5);
      chk("t4_count_empty", fifo_count, 0);
      chk("t4_flag_empty", flag_do, 0);

      // _txe rising during SETUP does not abort the byte in flight
      r0 = n_rises;
      push(8'h61, 1'b1);
      push(8'h62, 1'b1);
      txe_n = 1'b1;
      repeat (12) @(negedge system_clk);
      chk("t6_one_byte", n_rises - r0, 1);
      chk("t6_count_wait", fifo_count, 1);
      chk("t6_oe_idle", uart_d_oe, 0);
      txe_n = 1'b0;
      wait_drain(30, "t6_drain");
      chk("t6_two_bytes", n_rises - r0, 2);

      // Reset in STROBE aborts the strobe and flushes the FIFO
      push(8'h33, 1'b1);
      push(8'h34, 1'b1);
      push(8'h35, 1'b1);
      n = 0;
      @(negedge system_clk);
      while (uart_wr !== 1'b1 && n < 20) begin
         @(negedge system_clk);
         n++;
      end
      chk("t5_wr_seen", uart_wr, 1);
      reset = 1'b1;
      @(negedge system_clk);
      chk("t5_wr_abort", uart_wr, 0);
      chk("t5_oe_abort", uart_d_oe, 0);
      chk("t5_count_flush", fifo_count, 0);
      chk("t5_flag_flush", flag_do, 0);
      chk("t5_drop_clr", drop_count, 0);
      sb.delete();
      @(posedge system_clk);
      #1;
      reset = 1'b0;
      r0 = n_rises;
      push(8'h55, 1'b1);
      wait_drain(30, "t5_drain");
      chk("t5_new_byte", n_rises - r0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
